// File: rtl/adc_uart_pkg.sv
// Shared types and constants for the waveform-to-UART frame packer.
package adc_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_S_HI    = 3'd4,
    ST_S_LO    = 3'd5,
    ST_CSUM    = 3'd6,
    ST_DONE    = 3'd7
  } packer_state_t;

  localparam logic [7:0]  SYNC0   = 8'hA5;
  localparam logic [7:0]  SYNC1   = 8'h5A;
  localparam int unsigned HDR_LEN = 6;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/wave_uart_packer.sv
// Serialises one captured waveform into a framed byte stream:
// sync, wave number, sample count, samples (hi/lo), 8-bit checksum.
module wave_uart_packer
  import adc_uart_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 1000,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 14
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sel_fir,
  input  logic [15:0]       wave_num,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0]       N_WORD = 16'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [2:0]        I_LAST = 3'(HDR_LEN - 1);

  packer_state_t     state_q;
  logic [2:0]        idx_q;
  logic [ADDR_W-1:0] k_q;
  logic [15:0]       wave_q;
  logic [15:0]       sample_q;
  logic [7:0]        csum_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_sel_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              accept_d;
  logic [15:0]       rd_ext_d;
  logic [7:0]        csum_d;

  assign accept_d = tx_valid_q && tx_ready;
  assign rd_ext_d = 16'(rd_data);
  assign csum_d   = csum_add(csum_q, tx_data_q);

  function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [15:0] w);
    case (i)
      3'd0:    return SYNC0;
      3'd1:    return SYNC1;
      3'd2:    return w[15:8];
      3'd3:    return w[7:0];
      3'd4:    return N_WORD[15:8];
      3'd5:    return N_WORD[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      k_q        <= '0;
      wave_q     <= 16'h0000;
      sample_q   <= 16'h0000;
      csum_q     <= 8'h00;
      rd_addr_q  <= '0;
      rd_sel_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_HDR;
            idx_q      <= 3'd0;
            k_q        <= '0;
            csum_q     <= 8'h00;
            wave_q     <= wave_num;
            rd_sel_q   <= sel_fir;
            tx_data_q  <= SYNC0;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_HDR: begin
          if (accept_d) begin
            // Sync bytes (idx 0,1) are excluded from the checksum.
            if (idx_q >= 3'd2) csum_q <= csum_d;
            if (idx_q == I_LAST) begin
              state_q    <= ST_FETCH;
              tx_valid_q <= 1'b0;
              rd_addr_q  <= k_q;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= hdr_byte(idx_q + 3'd1, wave_q);
            end
          end
        end
        ST_FETCH: state_q <= ST_WAIT_RD;
        ST_WAIT_RD: begin
          sample_q   <= rd_ext_d;
          tx_data_q  <= rd_ext_d[15:8];
          tx_valid_q <= 1'b1;
          state_q    <= ST_S_HI;
        end
        ST_S_HI: begin
          if (accept_d) begin
            csum_q    <= csum_d;
            tx_data_q <= sample_q[7:0];
            state_q   <= ST_S_LO;
          end
        end
        ST_S_LO: begin
          if (accept_d) begin
            csum_q <= csum_d;
            if (k_q == K_LAST) begin
              tx_data_q <= csum_d;
              state_q   <= ST_CSUM;
            end else begin
              k_q        <= k_q + ADDR_W'(1);
              rd_addr_q  <= k_q + ADDR_W'(1);
              tx_valid_q <= 1'b0;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_CSUM: begin
          if (accept_d) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_sel   = rd_sel_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_wave_uart_packer.sv
// Scoreboard bench: a short 4-sample instance for handshake/control cases
// and a default 1000-sample instance for the full-length frame.
module tb_wave_uart_packer;

  localparam int NA = 4;
  localparam int NB = 1000;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic        reset_n;
  logic        start_a, sel_a, rd_sel_a, tx_valid_a, tx_ready_a, busy_a, done_a;
  logic [15:0] wave_a;
  logic [9:0]  rd_addr_a;
  logic [13:0] rd_data_a;
  logic [7:0]  tx_data_a;
  logic        start_b, sel_b, rd_sel_b, tx_valid_b, tx_ready_b, busy_b, done_b;
  logic [15:0] wave_b;
  logic [9:0]  rd_addr_b;
  logic [13:0] rd_data_b;
  logic [7:0]  tx_data_b;

  wave_uart_packer #(.N_SAMPLES(NA), .ADDR_W(10), .DATA_W(14)) dut_a (
    .clk_50(clk_50), .reset_n(reset_n), .start(start_a), .sel_fir(sel_a),
    .wave_num(wave_a), .rd_addr(rd_addr_a), .rd_sel(rd_sel_a), .rd_data(rd_data_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .done(done_a));

  wave_uart_packer dut_b (
    .clk_50(clk_50), .reset_n(reset_n), .start(start_b), .sel_fir(sel_b),
    .wave_num(wave_b), .rd_addr(rd_addr_b), .rd_sel(rd_sel_b), .rd_data(rd_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b));

  int total = 0;
  int bad   = 0;
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  logic [13:0] raw_mem[NA];
  logic [13:0] fir_mem[NA];
  logic        exp_sel_a = 1'b0;
  int          ready_mode_a = 0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  int          bytes_b = 0;
  logic [9:0]  max_addr_b = 10'd0;

  // Capture memories: read data valid one cycle after the address.
  always @(posedge clk_50) begin
    rd_data_a <= rd_sel_a ? fir_mem[rd_addr_a[1:0]] : raw_mem[rd_addr_a[1:0]];
    rd_data_b <= 14'h2AAA;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int which, input logic [7:0] b);
    if (which == 0) q_a.push_back(b);
    else q_b.push_back(b);
  endtask

  task automatic push_frame(input int which, input logic [15:0] w, input logic sel);
    logic [7:0]  cs, hi;
    logic [13:0] s;
    int n;
    n  = (which == 0) ? NA : NB;
    push_byte(which, 8'hA5);
    push_byte(which, 8'h5A);
    push_byte(which, w[15:8]);
    push_byte(which, w[7:0]);
    push_byte(which, 8'(n >> 8));
    push_byte(which, 8'(n));
    cs = w[15:8] + w[7:0] + 8'(n >> 8) + 8'(n);
    for (int k = 0; k < n; k++) begin
      s  = (which != 0) ? 14'h2AAA : (sel ? fir_mem[k] : raw_mem[k]);
      hi = {2'b00, s[13:8]};
      push_byte(which, hi);
      push_byte(which, s[7:0]);
      cs = cs + hi + s[7:0];
    end
    push_byte(which, cs);
  endtask

  // Ready pattern, changed just after each rising edge.
  initial begin
    int cyc;
    cyc = 0;
    tx_ready_a = 1'b1;
    tx_ready_b = 1'b1;
    forever begin
      @(posedge clk_50);
      #1;
      cyc++;
      tx_ready_a = (ready_mode_a == 0) ? 1'b1 : (cyc % 4 == 0);
    end
  end

  // Monitor A: byte scoreboard, stall hold, rd_sel hold, done width.
  initial begin
    logic       stall, done_prev;
    logic [7:0] held;
    stall = 1'b0; done_prev = 1'b0; held = 8'h00;
    forever begin
      @(negedge clk_50);
      if (!reset_n) begin
        stall = 1'b0; done_prev = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid_a", 32'(tx_valid_a), 32'd1);
          check("hold_data_a", 32'(tx_data_a), 32'(held));
        end
        if (tx_valid_a && tx_ready_a) begin
          if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_byte_a: got %0h expected no byte", tx_data_a);
          end else check("byte_a", 32'(tx_data_a), 32'(q_a.pop_front()));
        end
        if (busy_a) check("rd_sel_a", 32'(rd_sel_a), 32'(exp_sel_a));
        if (done_a) begin
          done_cnt_a++;
          if (done_prev) begin
            total++; bad++;
            $display("FAIL done_width_a: got 2+ cycles expected 1");
          end
        end
        stall = tx_valid_a && !tx_ready_a;
        held = tx_data_a;
        done_prev = done_a;
      end
    end
  end

  // Monitor B: byte scoreboard and highest address seen.
  initial begin
    forever begin
      @(negedge clk_50);
      if (reset_n) begin
        if (rd_addr_b > max_addr_b) max_addr_b = rd_addr_b;
        if (tx_valid_b && tx_ready_b) begin
          bytes_b++;
          if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_byte_b: got %0h expected no byte", tx_data_b);
          end else check("byte_b", 32'(tx_data_b), 32'(q_b.pop_front()));
        end
        if (done_b) done_cnt_b++;
      end
    end
  end

  task automatic wait_done_a(input int prev);
    for (int i = 0; i < 3000 && done_cnt_a == prev; i++) @(negedge clk_50);
    check("done_seen_a", 32'(done_cnt_a), 32'(prev + 1));
  endtask

  task automatic run_a(input logic [15:0] w, input logic sel, input int mode, input bit inject);
    int prev;
    prev = done_cnt_a;
    exp_sel_a = sel;
    ready_mode_a = mode;
    push_frame(0, w, sel);
    @(negedge clk_50);
    start_a = 1'b1; sel_a = sel; wave_a = w;
    @(negedge clk_50);
    start_a = 1'b0; sel_a = ~sel; wave_a = 16'hDEAD;
    check("busy_after_start", 32'(busy_a), 32'd1);
    check("valid_latency", 32'(tx_valid_a), 32'd1);
    check("first_byte", 32'(tx_data_a), 32'hA5);
    if (inject) begin
      start_a = 1'b1; wave_a = 16'hFFFF;
      @(negedge clk_50);
      start_a = 1'b0;
      for (int i = 0; i < 200 && !(rd_addr_a == 10'd1 && tx_valid_a); i++) @(negedge clk_50);
      start_a = 1'b1;
      repeat (2) @(negedge clk_50);
      start_a = 1'b0;
    end
    wait_done_a(prev);
    check("queue_empty_a", 32'(q_a.size()), 32'd0);
    repeat (4) @(negedge clk_50);
    check("busy_low_a", 32'(busy_a), 32'd0);
    check("valid_low_a", 32'(tx_valid_a), 32'd0);
    check("one_frame_a", 32'(done_cnt_a), 32'(prev + 1));
  endtask

  initial begin
    int prev;
    raw_mem = '{14'h0000, 14'h0001, 14'h0002, 14'h3FFF};
    fir_mem = '{14'h1555, 14'h0ABC, 14'h3F00, 14'h00FF};
    reset_n = 1'b0;
    start_a = 1'b0; sel_a = 1'b0; wave_a = 16'h0000;
    start_b = 1'b0; sel_b = 1'b0; wave_b = 16'h0000;
    repeat (3) @(negedge clk_50);
    check("rst_tx_data", 32'(tx_data_a), 32'd0);
    check("rst_tx_valid", 32'(tx_valid_a), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_a), 32'd0);
    check("rst_rd_sel", 32'(rd_sel_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);

    run_a(16'h1234, 1'b0, 0, 1'b0);
    run_a(16'h1234, 1'b0, 1, 1'b0);
    run_a(16'hBEEF, 1'b0, 0, 1'b1);
    run_a(16'h0F0F, 1'b1, 1, 1'b0);

    // Abort mid-frame while sample 2 is in flight.
    prev = done_cnt_a;
    exp_sel_a = 1'b0;
    ready_mode_a = 0;
    push_frame(0, 16'h5555, 1'b0);
    @(negedge clk_50);
    start_a = 1'b1; sel_a = 1'b0; wave_a = 16'h5555;
    @(negedge clk_50);
    start_a = 1'b0;
    for (int i = 0; i < 200 && rd_addr_a != 10'd2; i++) @(negedge clk_50);
    @(negedge clk_50);
    check("pre_abort_busy", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_tx_valid", 32'(tx_valid_a), 32'd0);
    check("abort_tx_data", 32'(tx_data_a), 32'd0);
    check("abort_rd_addr", 32'(rd_addr_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    q_a.delete();
    repeat (2) @(negedge clk_50);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_50);
    check("abort_no_done", 32'(done_cnt_a), 32'(prev));
    run_a(16'h4321, 1'b0, 0, 1'b0);

    // Full-length frame on the default-sized instance.
    prev = done_cnt_b;
    push_frame(1, 16'h0000, 1'b0);
    @(negedge clk_50);
    start_b = 1'b1;
    @(negedge clk_50);
    start_b = 1'b0;
    for (int i = 0; i < 20000 && done_cnt_b == prev; i++) @(negedge clk_50);
    check("done_seen_b", 32'(done_cnt_b), 32'(prev + 1));
    check("queue_empty_b", 32'(q_b.size()), 32'd0);
    check("byte_count_b", 32'(bytes_b), 32'd2007);
    check("max_addr_b", 32'(max_addr_b), 32'd999);
    check("final_addr_b", 32'(rd_addr_b), 32'd999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
